lag_pl_status_tracker: RTL and testbench
========================================

# lag_pl_status_tracker

- Per-output-port controller that owns the free/allocated state of every physical link (PL) in each output trunk.
- Generates the registered `pl_status` vector consumed by the PL allocator.
  - Marks a PL busy when the allocator grants it.
  - Returns the PL to the free pool once the packet's tail flit has left.
- Tracks downstream buffer credits per PL and publishes a per-PL "can send" flag to the switch/output stage.

## Interface
- `np`, 5, number of router ports.
- `max_links_num`, 2, maximum PLs per trunk (per port).
- `buf_len`, 4, downstream buffer depth per PL; reset and maximum credit count.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `pl_allocated`  input  [np-1:0][max_links_num-1:0]  allocator granted this output PL this cycle.
- `flit_sent`  input  [np-1:0][max_links_num-1:0]  a flit left on this output PL this cycle.
- `tail_sent`  input  [np-1:0][max_links_num-1:0]  the flit sent this cycle is a tail; only meaningful with `flit_sent`.
- `credit_in`  input  [np-1:0][max_links_num-1:0]  downstream freed one buffer slot of this PL.
- `pl_status`  output  [np-1:0][max_links_num-1:0]  1 = PL free and allocatable; registered.
- `pl_has_credit`  output  [np-1:0][max_links_num-1:0]  credit counter > 0; registered.
- `protocol_err`  output  1  sticky error flag; cleared only by reset.

## Operation
- Each (port, link) pair holds one state machine and one credit counter.
  - Width of the credit counter: `$clog2(buf_len+1)`.
  - Only link indices below `max_links_num` exist. There is no per-port link-count parameter; unused links are simply never driven.
- State machine states: FREE, ACTIVE, DRAIN. DRAIN exists only with the macro; see Configuration.
  - FREE -> ACTIVE on `pl_allocated`.
  - ACTIVE -> FREE on `flit_sent && tail_sent` (no macro).
  - ACTIVE -> DRAIN on the same event (with macro).
  - DRAIN -> FREE when the counter equals `buf_len`, including the increment from this cycle's `credit_in`.
- `pl_status` = 1 exactly in FREE.
- Credit counter update each cycle:
  - `credit_in` only: +1.
  - `flit_sent` only: -1.
  - Both: unchanged.
- Protocol errors; each sets `protocol_err`, and the illegal part has no other effect:
  - `pl_allocated` while not FREE: ignored.
  - `flit_sent` in FREE or DRAIN: no decrement.
  - `flit_sent` with counter 0: counter stays 0.
  - `credit_in` with counter `buf_len` and no simultaneous `flit_sent`: counter stays `buf_len`.
- Single-flit packet: an allocation in cycle t followed by head+tail sent in cycle t+1 is legal. FREE->ACTIVE happens at edge t, ACTIVE->FREE (or DRAIN) at edge t+1.

## Timing
- Reset values:
  - All states FREE.
  - All counters `buf_len`.
  - `pl_status` all 1.
  - `pl_has_credit` all 1.
  - `protocol_err` 0.
- Reset asserted mid-packet forces the reset values immediately (asynchronous); in-flight packets are abandoned.
- `pl_allocated` in cycle t -> `pl_status` 0 from cycle t+1. The allocator therefore sees the PL busy one cycle after its grant and must not re-grant it in the same cycle.
- Tail sent in cycle t -> `pl_status` 1 from cycle t+1 (no macro).
- `pl_has_credit` reflects the counter after the cycle-t update, visible in t+1. There is no combinational input-to-output path.

## Configuration
- `LAG_PL_FREE_ON_CREDITS_EN` defined:
  - Atomic buffer allocation: after the tail, the PL enters DRAIN.
  - It returns to FREE only when all `buf_len` credits are back, so a new packet never shares a downstream buffer with the previous one.
- Undefined:
  - The DRAIN state is not compiled.
  - The PL is free the cycle after the tail is sent, regardless of credits.

## Structure
- Shared package (`LAG_pkg`, alongside existing router types):
  - `pl_state_t` enum (FREE, ACTIVE, DRAIN).
  - A credit-width constant function.
- Sub-module `lag_pl_credit_counter`, one per (port, link):
  - Parameter `buf_len`; inputs `inc`, `dec`.
  - Outputs: `count`, `nonzero`, `full`, `err`.
- Top level instantiates the counters in generate loops.
- Per-link state machines live in an array in the top level.
- `protocol_err` is the registered OR of all per-link error events.

## Test plan
- Reset, no stimulus -> all `pl_status`=1, `pl_has_credit`=1, `protocol_err`=0.
- `pl_allocated[1][0]` at t, then 3 flits on [1][0] with tail on the 3rd at t+3 (no macro):
  - `pl_status[1][0]`=0 for t+1..t+3 and 1 at t+4.
  - Counter 1, so `pl_has_credit` stays 1.
- Same sequence with macro and `buf_len`=4, credits returned at t+5, t+6, t+7:
  - DRAIN through t+7.
  - `pl_status[1][0]`=1 at t+8.
- Link [2][1]: 4 flits without credits -> `pl_has_credit[2][1]`=0 after the 4th. A 5th `flit_sent` then raises `protocol_err` and leaves the counter at 0.
- Simultaneous `flit_sent` and `credit_in` on [0][0] with counter 2 -> counter stays 2 and no error.
- `pl_allocated[3][0]` while ACTIVE -> state unchanged and `protocol_err`=1. Then `rst_n` low mid-packet -> all outputs at their reset values immediately.

Source files
------------

// File: rtl/LAG_pkg.sv
// rtl/LAG_pkg.sv - shared router types: PL state encoding and credit counter width
package LAG_pkg;

`ifdef LAG_PL_FREE_ON_CREDITS_EN
    typedef enum logic [1:0] {
        PL_FREE,
        PL_ACTIVE,
        PL_DRAIN
    } pl_state_t;
`else
    typedef enum logic [0:0] {
        PL_FREE,
        PL_ACTIVE
    } pl_state_t;
`endif

    // Counter must hold every value 0..depth inclusive.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lag_pl_status_tracker_if.sv
// rtl/lag_pl_status_tracker_if.sv - allocator/switch side signals of the PL status tracker
interface lag_pl_status_tracker_if #(
    parameter int np            = 5,
    parameter int max_links_num = 2
);
    logic [np-1:0][max_links_num-1:0] pl_allocated;
    logic [np-1:0][max_links_num-1:0] flit_sent;
    logic [np-1:0][max_links_num-1:0] tail_sent;
    logic [np-1:0][max_links_num-1:0] credit_in;
    logic [np-1:0][max_links_num-1:0] pl_status;
    logic [np-1:0][max_links_num-1:0] pl_has_credit;
    logic                             protocol_err;

    modport master (
        output pl_allocated, flit_sent, tail_sent, credit_in,
        input  pl_status, pl_has_credit, protocol_err
    );

    modport slave (
        input  pl_allocated, flit_sent, tail_sent, credit_in,
        output pl_status, pl_has_credit, protocol_err
    );
endinterface

// File: rtl/lag_pl_status_tracker_credit_counter.sv
// rtl/lag_pl_status_tracker_credit_counter.sv - saturating downstream credit counter for one PL
module lag_pl_credit_counter
    import LAG_pkg::*;
#(
    parameter int buf_len = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic                         dec,
    output logic [credit_w(buf_len)-1:0] count,
    output logic                         nonzero,
    output logic                         full,
    output logic                         err
);
    localparam int            cw        = credit_w(buf_len);
    localparam logic [cw-1:0] max_count = cw'(buf_len);

    logic [cw-1:0] count_nxt;

    // Next count; an overflow or underflow is flagged and leaves the count alone.
    always_comb begin
        count_nxt = count;
        err       = 1'b0;
        if (inc && !dec) begin
            if (count == max_count) err = 1'b1;
            else                    count_nxt = count + 1'b1;
        end else if (dec && !inc) begin
            if (count == '0) err = 1'b1;
            else             count_nxt = count - 1'b1;
        end
    end

    // Credit register; the downstream buffer starts empty, so all credits are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= max_count;
        else        count <= count_nxt;
    end

    assign nonzero = (count != '0);
    assign full    = (count == max_count);
endmodule

// File: rtl/lag_pl_status_tracker.sv
// rtl/lag_pl_status_tracker.sv - per-link PL free/busy and credit tracker; option LAG_PL_FREE_ON_CREDITS_EN
module lag_pl_status_tracker
    import LAG_pkg::*;
#(
    parameter int np            = 5,
    parameter int max_links_num = 2,
    parameter int buf_len       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lag_pl_status_tracker_if.slave bus
);
    localparam int cw = credit_w(buf_len);

    pl_state_t state [np][max_links_num];

    logic [np-1:0][max_links_num-1:0]         cnt_dec;
    logic [np-1:0][max_links_num-1:0]         cnt_nonzero;
    logic [np-1:0][max_links_num-1:0]         cnt_full;
    logic [np-1:0][max_links_num-1:0]         cnt_err;
    logic [np-1:0][max_links_num-1:0]         link_err;
    logic [np-1:0][max_links_num-1:0][cw-1:0] cnt;
    logic                                     protocol_err_q;

    for (genvar p = 0; p < np; p++) begin : g_port
        for (genvar l = 0; l < max_links_num; l++) begin : g_link
            lag_pl_credit_counter #(.buf_len(buf_len)) u_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .inc     (bus.credit_in[p][l]),
                .dec     (cnt_dec[p][l]),
                .count   (cnt[p][l]),
                .nonzero (cnt_nonzero[p][l]),
                .full    (cnt_full[p][l]),
                .err     (cnt_err[p][l])
            );
        end
    end

    // A flit only consumes a credit while its packet owns the PL.
    always_comb begin
        cnt_dec = '0;
        for (int p = 0; p < np; p++)
            for (int l = 0; l < max_links_num; l++)
                cnt_dec[p][l] = bus.flit_sent[p][l] && (state[p][l] == PL_ACTIVE);
    end

    // Illegal events per link: re-grant of a busy PL, flit on a PL with no packet, credit faults.
    always_comb begin
        link_err = '0;
        for (int p = 0; p < np; p++)
            for (int l = 0; l < max_links_num; l++)
                link_err[p][l] = (bus.pl_allocated[p][l] && (state[p][l] != PL_FREE))
                               || (bus.flit_sent[p][l] && (state[p][l] != PL_ACTIVE))
                               || cnt_err[p][l];
    end

`ifdef LAG_PL_FREE_ON_CREDITS_EN
    localparam logic [cw-1:0] one_short = cw'(buf_len - 1);

    logic [np-1:0][max_links_num-1:0] drain_done;

    // All credits home after this cycle's update (no decrement can occur while draining).
    always_comb begin
        drain_done = '0;
        for (int p = 0; p < np; p++)
            for (int l = 0; l < max_links_num; l++)
                drain_done[p][l] = cnt_full[p][l]
                                 || ((cnt[p][l] == one_short) && bus.credit_in[p][l]);
    end
`else
    logic unused_credit_state;
    assign unused_credit_state = ^{cnt, cnt_full};
`endif

    // Per-link ownership state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < np; p++)
                for (int l = 0; l < max_links_num; l++)
                    state[p][l] <= PL_FREE;
        end else begin
            for (int p = 0; p < np; p++)
                for (int l = 0; l < max_links_num; l++)
                    case (state[p][l])
                        PL_FREE:
                            if (bus.pl_allocated[p][l]) state[p][l] <= PL_ACTIVE;
                        PL_ACTIVE:
                            if (bus.flit_sent[p][l] && bus.tail_sent[p][l])
`ifdef LAG_PL_FREE_ON_CREDITS_EN
                                state[p][l] <= PL_DRAIN;
                        PL_DRAIN:
                            if (drain_done[p][l]) state[p][l] <= PL_FREE;
`else
                                state[p][l] <= PL_FREE;
`endif
                        default:
                            state[p][l] <= PL_FREE;
                    endcase
        end
    end

    // Sticky protocol error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         protocol_err_q <= 1'b0;
        else if (|link_err) protocol_err_q <= 1'b1;
    end

    // Free flag decoded straight from the state register.
    always_comb begin
        bus.pl_status = '0;
        for (int p = 0; p < np; p++)
            for (int l = 0; l < max_links_num; l++)
                bus.pl_status[p][l] = (state[p][l] == PL_FREE);
    end

    assign bus.pl_has_credit = cnt_nonzero;
    assign bus.protocol_err  = protocol_err_q;
endmodule

// File: tb/tb_lag_pl_status_tracker.sv
// tb/tb_lag_pl_status_tracker.sv - scoreboard bench for lag_pl_status_tracker
module tb_lag_pl_status_tracker;
    typedef logic [4:0][1:0] vec_t;
    typedef struct {
        int    due;
        string name;
        vec_t  st;
        vec_t  cr;
        logic  er;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lag_pl_status_tracker_if #(.np(5), .max_links_num(2)) bus ();

    lag_pl_status_tracker #(.np(5), .max_links_num(2), .buf_len(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t es;
    vec_t ec;
    logic ee;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check3(input string nm, input vec_t st, input vec_t cr, input logic er,
                          input vec_t xst, input vec_t xcr, input logic xer);
        n_vec++;
        if (st !== xst) begin
            n_err++;
            $display("FAIL %s pl_status got %b want %b", nm, st, xst);
        end
        n_vec++;
        if (cr !== xcr) begin
            n_err++;
            $display("FAIL %s pl_has_credit got %b want %b", nm, cr, xcr);
        end
        n_vec++;
        if (er !== xer) begin
            n_err++;
            $display("FAIL %s protocol_err got %b want %b", nm, er, xer);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL %s not checked in time: due %0d now %0d", e.name, e.due, cyc);
            end else begin
                check3(e.name, bus.pl_status, bus.pl_has_credit, bus.protocol_err, e.st, e.cr, e.er);
            end
        end
    end

    function automatic vec_t bit_at(input int p, input int l);
        vec_t v;
        v = '0;
        v[p][l] = 1'b1;
        return v;
    endfunction

    task automatic step(input string nm, input vec_t a, input vec_t f, input vec_t t, input vec_t c);
        exp_t e;
        @(posedge clk);
        #1;
        bus.pl_allocated = a;
        bus.flit_sent    = f;
        bus.tail_sent    = t;
        bus.credit_in    = c;
        e.due  = cyc + 1;
        e.name = nm;
        e.st   = es;
        e.cr   = ec;
        e.er   = ee;
        sb.push_back(e);
    endtask

    task automatic drain(input string nm);
        int n;
        step({nm, "_idle"}, '0, '0, '0, '0);
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s scoreboard not empty: got %0d entries want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.pl_allocated = '0;
        bus.flit_sent    = '0;
        bus.tail_sent    = '0;
        bus.credit_in    = '0;
        es = '1;
        ec = '1;
        ee = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        vec_t b10, b00, b30, b31, b21, b41, b40;
        b10 = bit_at(1, 0);
        b00 = bit_at(0, 0);
        b30 = bit_at(3, 0);
        b31 = bit_at(3, 1);
        b21 = bit_at(2, 1);
        b41 = bit_at(4, 1);
        b40 = bit_at(4, 0);

        do_reset();
        step("reset", '0, '0, '0, '0);

        // three-flit packet on [1][0], credits back later
        es[1][0] = 1'b0;
        step("a_alloc", b10, '0, '0, '0);
        step("a_flit1", '0, b10, '0, '0);
        step("a_flit2", '0, b10, '0, '0);
`ifndef LAG_PL_FREE_ON_CREDITS_EN
        es[1][0] = 1'b1;
`endif
        step("a_tail", '0, b10, b10, '0);
        step("a_gap", '0, '0, '0, '0);
        step("a_cr1", '0, '0, '0, b10);
        step("a_cr2", '0, '0, '0, b10);
        es[1][0] = 1'b1;
        step("a_cr3", '0, '0, '0, b10);
        drain("a");

        // counter at 2, flit and credit together
        es[0][0] = 1'b0;
        step("c_alloc", b00, '0, '0, '0);
        step("c_flit1", '0, b00, '0, '0);
        step("c_flit2", '0, b00, '0, '0);
        step("c_both", '0, b00, '0, b00);
        step("c_flit3", '0, b00, '0, '0);
        ec[0][0] = 1'b0;
        step("c_flit4", '0, b00, '0, '0);
        ec[0][0] = 1'b1;
        step("c_credit", '0, '0, '0, b00);
        drain("c");

        // re-grant of a busy PL
        es[3][0] = 1'b0;
        step("d_alloc", b30, '0, '0, '0);
        ee = 1'b1;
        step("d_realloc", b30, '0, '0, '0);
        drain("d");
        es[3][1] = 1'b0;
        step("d_alloc31", b31, '0, '0, '0);
        drain("d2");

        // asynchronous reset mid-packet
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check3("async_reset", bus.pl_status, bus.pl_has_credit, bus.protocol_err, '1, '1, 1'b0);
        bus.pl_allocated = '0;
        es = '1;
        ec = '1;
        ee = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step("post_reset", '0, '0, '0, '0);

        // drain credits of [2][1] to zero, then underflow
        es[2][1] = 1'b0;
        step("b_alloc", b21, '0, '0, '0);
        step("b_flit1", '0, b21, '0, '0);
        step("b_flit2", '0, b21, '0, '0);
        step("b_flit3", '0, b21, '0, '0);
        ec[2][1] = 1'b0;
        step("b_flit4", '0, b21, '0, '0);
        ee = 1'b1;
        step("b_flit5", '0, b21, '0, '0);
        ec[2][1] = 1'b1;
        step("b_credit", '0, '0, '0, b21);
        drain("b");

        // flit on a free PL
        do_reset();
        step("e_reset", '0, '0, '0, '0);
        ee = 1'b1;
        step("e_flit_free", '0, b41, '0, '0);
        drain("e");

        // credit overflow on a full counter
        do_reset();
        step("f_reset", '0, '0, '0, '0);
        ee = 1'b1;
        step("f_overflow", '0, '0, '0, b40);
        drain("f");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
